usb_rw_ctrl: RTL and testbench
==============================

# usb_rw_ctrl

Protocol sequencer for the host side of the USB memory-access link. It turns one task-level memory request (16-bit address, 64-bit data, read or write) into the required pair of bus transactions:
- an address transaction to the address endpoint;
- a data OUT or IN transaction to the data endpoint.

It issues them one at a time to the packet/transaction engine below it, retries failed attempts, enforces a watchdog, and returns a single success/fail response with read data.

## Interface
Parameters:
- DEV_ADDR, 7'd5, USB device address driven on every transaction
- ADDR_ENDP, 4'd4, endpoint receiving the memory address
- DATA_ENDP, 4'd8, endpoint receiving or supplying memory data
- MAX_TRIES, 8, attempts per transaction before abort (legal range 1-15)
- TIMEOUT, 255, cycles waited for txn_done before an attempt counts as failed (legal range 1-255)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_L  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  16  memory address
- req_wdata  in  64  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_success  out  1  request completed, qualified by rsp_valid
- rsp_rdata  out  64  read data; 0 for writes and failures
- txn_start  out  1  one-cycle pulse launching a transaction
- txn_is_in  out  1  1 = IN transaction, 0 = OUT transaction
- txn_dev  out  7  device address, always DEV_ADDR
- txn_endp  out  4  endpoint number
- txn_wdata  out  64  OUT payload
- txn_done  in  1  one-cycle completion pulse from the engine
- txn_ok  in  1  attempt succeeded (ACK / clean DATA), qualified by txn_done
- txn_rdata  in  64  IN payload, qualified by txn_done && txn_ok

## Operation
States: IDLE, A_ISSUE, A_WAIT, D_ISSUE, D_WAIT, RESP.

- **IDLE**
  - req_ready = 1.
  - On req_valid: latch write, addr and wdata; clear the try counter; go to A_ISSUE.
- **A_ISSUE**
  - Pulse txn_start with txn_is_in = 0, txn_endp = ADDR_ENDP, txn_wdata = {48'h0, addr}.
  - Increment the try counter; load the watchdog with TIMEOUT; go to A_WAIT.
- **A_WAIT**
  - txn_done && txn_ok: clear the try counter; go to D_ISSUE.
  - Failure, meaning txn_done && !txn_ok, or the watchdog reaching 0:
    - if tries == MAX_TRIES, go to RESP with fail;
    - otherwise go back to A_ISSUE.
- **D_ISSUE**
  - Pulse txn_start with txn_endp = DATA_ENDP.
  - Write: txn_is_in = 0, txn_wdata = latched wdata. Read: txn_is_in = 1, txn_wdata = 0.
  - Increment the try counter; reload the watchdog; go to D_WAIT.
- **D_WAIT**
  - Success: capture txn_rdata if reading; go to RESP with success.
  - Failure: handled as in A_WAIT, but retries go back to D_ISSUE.
- **RESP**
  - rsp_valid = 1; rsp_success set as decided above; rsp_rdata = captured data (0 for a write or a fail).
  - Go to IDLE.

Additional rules:
- The retry budget is independent per phase. A write can therefore take up to 2*MAX_TRIES attempts.
- A failed address phase never starts a data phase.
- txn_is_in, txn_endp and txn_wdata are held stable from the txn_start cycle until the state leaves *_WAIT.
- txn_done outside A_WAIT/D_WAIT is ignored and causes no state change.
- If txn_done arrives in the same cycle the watchdog reaches 0, txn_done wins.
- The watchdog decrements once per cycle in *_WAIT. The try counter is 4 bits and never wraps, because MAX_TRIES ≤ 15.

## Timing
- **Reset:** while rst_L is low, state = IDLE, req_ready = 1, rsp_valid = 0, rsp_success = 0, rsp_rdata = 0, txn_start = 0, txn_is_in = 0, txn_endp = 0, txn_wdata = 0, txn_dev = DEV_ADDR. Counters are cleared.
- **Reset mid-request:** the request is abandoned and no rsp_valid is produced.
- **Request handshake:** the request is accepted on the cycle where req_valid && req_ready. req_ready drops the next cycle.
- **Address launch:** txn_start first asserts 1 cycle after acceptance.
- **Phase-to-phase latency:**
  - A txn_done at cycle t (in A_WAIT) produces the data txn_start at t+1.
  - A failed attempt at t produces the retry txn_start at t+1.
- **Response:** a successful D_WAIT txn_done at t produces rsp_valid at t+1. req_ready rises at t+2.
- **Best case:** acceptance at T; address transaction done at T+1+k1; data done at T+2+k1+k2; rsp_valid at T+3+k1+k2.
- **Watchdog:** with no txn_done, an attempt fails after exactly TIMEOUT cycles in *_WAIT.
- **Back-to-back requests:** a new request can be accepted on the cycle after RESP.

## Test plan
- **Write, all success:** write addr 16'hFFFF, data 64'hFFFF_FFFF_FFFF_FFFF, engine ACKs both transactions → exactly two txn_start pulses: (OUT, endp 4, wdata 64'h0000_0000_0000_FFFF), then (OUT, endp 8, wdata all-ones). One rsp_valid with rsp_success = 1, rsp_rdata = 0.
- **Read, all success:** read addr 16'h1234, engine returns 64'hDEAD_BEEF_0123_4567 → second transaction has txn_is_in = 1, endp 8. rsp_rdata = 64'hDEAD_BEEF_0123_4567, rsp_success = 1.
- **Retry then succeed:** data phase NAKs (txn_ok = 0) 7 times, then ACKs → 1 address txn_start + 8 data txn_starts. rsp_success = 1.
- **Exhaustion:** address phase fails 8 times → exactly 8 txn_starts, all to endp 4, and no endp-8 transaction. rsp_success = 0, rsp_rdata = 0.
- **Watchdog:** engine never pulses txn_done, TIMEOUT = 255 → each retry txn_start occurs 256 cycles after the previous one. After 8 attempts, rsp_valid with rsp_success = 0. A txn_done coinciding with watchdog expiry counts as completion.
- **Reset mid-operation:** assert rst_L = 0 during D_WAIT of a write, then release → all outputs at reset values, no rsp_valid. A following write completes normally.

Source files
------------

// File: rtl/usb_rw_ctrl_if.sv
// Request/response and transaction-engine signal bundle for usb_rw_ctrl.
interface usb_rw_ctrl_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEV_W  = 7;
    localparam int unsigned ENDP_W = 4;

    // task-level request / response
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_success;
    logic [DATA_W-1:0] rsp_rdata;

    // transaction engine
    logic              txn_start;
    logic              txn_is_in;
    logic [DEV_W-1:0]  txn_dev;
    logic [ENDP_W-1:0] txn_endp;
    logic [DATA_W-1:0] txn_wdata;
    logic              txn_done;
    logic              txn_ok;
    logic [DATA_W-1:0] txn_rdata;

    // sequencer side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  txn_done, txn_ok, txn_rdata,
        output req_ready, rsp_valid, rsp_success, rsp_rdata,
        output txn_start, txn_is_in, txn_dev, txn_endp, txn_wdata
    );

    // requester + engine side
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output txn_done, txn_ok, txn_rdata,
        input  req_ready, rsp_valid, rsp_success, rsp_rdata,
        input  txn_start, txn_is_in, txn_dev, txn_endp, txn_wdata
    );
endinterface

// File: rtl/usb_rw_ctrl.sv
// Host-side USB memory-access sequencer: one request becomes an address
// transaction followed by a data transaction, each with its own retry budget
// and a per-attempt watchdog, ending in a single success/fail response.
module usb_rw_ctrl #(
    parameter logic [6:0]  DEV_ADDR  = 7'd5,
    parameter logic [3:0]  ADDR_ENDP = 4'd4,
    parameter logic [3:0]  DATA_ENDP = 4'd8,
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst_L,
    usb_rw_ctrl_if.slave bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ENDP_W = 4;
    localparam int unsigned TRY_W  = 4;
    localparam int unsigned WDOG_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_A_ISSUE,
        S_A_WAIT,
        S_D_ISSUE,
        S_D_WAIT,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_success_q, rsp_success_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                txn_start_q, txn_start_d;
    logic                txn_is_in_q, txn_is_in_d;
    logic [ENDP_W-1:0]   txn_endp_q, txn_endp_d;
    logic [DATA_W-1:0]   txn_wdata_q, txn_wdata_d;

    logic                attempt_ok_c;
    logic                attempt_fail_c;
    logic                budget_spent_c;

    // Attempt outcome: a completion pulse takes priority over watchdog expiry.
    always_comb begin
        attempt_ok_c   = bus.txn_done && bus.txn_ok;
        attempt_fail_c = (bus.txn_done && !bus.txn_ok) ||
                         (!bus.txn_done && (wdog_q <= WDOG_W'(1)));
        budget_spent_c = (tries_q >= TRY_W'(MAX_TRIES));
    end

    // Next-state logic; outputs are registered from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tries_d       = tries_q;
        wdog_d        = wdog_q;
        req_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_success_d = 1'b0;
        rsp_rdata_d   = '0;
        txn_start_d   = 1'b0;
        txn_is_in_d   = txn_is_in_q;
        txn_endp_d    = txn_endp_q;
        txn_wdata_d   = txn_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    tries_d = '0;
                    state_d = S_A_ISSUE;
                end
            end

            S_A_ISSUE: begin
                tries_d = tries_q + TRY_W'(1);
                wdog_d  = WDOG_W'(TIMEOUT);
                state_d = S_A_WAIT;
            end

            S_A_WAIT: begin
                if (wdog_q != '0) begin
                    wdog_d = wdog_q - WDOG_W'(1);
                end
                if (attempt_ok_c) begin
                    tries_d = '0;
                    state_d = S_D_ISSUE;
                end else if (attempt_fail_c) begin
                    // an exhausted address phase responds without a data phase
                    state_d = budget_spent_c ? S_RESP : S_A_ISSUE;
                end
            end

            S_D_ISSUE: begin
                tries_d = tries_q + TRY_W'(1);
                wdog_d  = WDOG_W'(TIMEOUT);
                state_d = S_D_WAIT;
            end

            S_D_WAIT: begin
                if (wdog_q != '0) begin
                    wdog_d = wdog_q - WDOG_W'(1);
                end
                if (attempt_ok_c) begin
                    rsp_success_d = 1'b1;
                    rsp_rdata_d   = write_q ? '0 : bus.txn_rdata;
                    state_d       = S_RESP;
                end else if (attempt_fail_c) begin
                    state_d = budget_spent_c ? S_RESP : S_D_ISSUE;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        txn_start_d = (state_d == S_A_ISSUE) || (state_d == S_D_ISSUE);

        // Transaction fields change only on launch and hold through the wait.
        if (state_d == S_A_ISSUE) begin
            txn_is_in_d = 1'b0;
            txn_endp_d  = ADDR_ENDP;
            txn_wdata_d = {{(DATA_W-ADDR_W){1'b0}}, addr_d};
        end else if (state_d == S_D_ISSUE) begin
            txn_is_in_d = !write_d;
            txn_endp_d  = DATA_ENDP;
            txn_wdata_d = write_d ? wdata_d : '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            tries_q       <= '0;
            wdog_q        <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_success_q <= 1'b0;
            rsp_rdata_q   <= '0;
            txn_start_q   <= 1'b0;
            txn_is_in_q   <= 1'b0;
            txn_endp_q    <= '0;
            txn_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            tries_q       <= tries_d;
            wdog_q        <= wdog_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_success_q <= rsp_success_d;
            rsp_rdata_q   <= rsp_rdata_d;
            txn_start_q   <= txn_start_d;
            txn_is_in_q   <= txn_is_in_d;
            txn_endp_q    <= txn_endp_d;
            txn_wdata_q   <= txn_wdata_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_success = rsp_success_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.txn_start   = txn_start_q;
    assign bus.txn_is_in   = txn_is_in_q;
    assign bus.txn_dev     = DEV_ADDR;
    assign bus.txn_endp    = txn_endp_q;
    assign bus.txn_wdata   = txn_wdata_q;
endmodule

// File: tb/tb_usb_rw_ctrl.sv
// Self-checking bench for usb_rw_ctrl: a scripted engine answers each
// txn_start, and a request-level model predicts every launch cycle/field and
// the final response.
module tb_usb_rw_ctrl;
    localparam int unsigned MT  = 8;
    localparam int unsigned TO  = 255;
    localparam logic [1:0] K_ACK = 2'd0;
    localparam logic [1:0] K_NAK = 2'd1;
    localparam logic [1:0] K_SIL = 2'd2;

    typedef struct packed {
        logic [31:0] cyc;
        logic        is_in;
        logic [3:0]  endp;
        logic [63:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [31:0] n;
        logic        succ;
        logic [63:0] rdata;
        logic [31:0] cyc;
    } rsp_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  dly;
        logic [63:0] rdata;
    } act_t;

    logic clk;
    logic rst_L;
    int   cyc = 0;
    int   vectors;
    int   miscompares;
    int   spur_req;
    bit   rdy_after;

    txn_t obs_txn[$];
    txn_t exp_txn[$];
    rsp_t obs_rsp;
    rsp_t exp_rsp;
    act_t script[$];
    act_t eng_q[$];

    usb_rw_ctrl_if bus();

    usb_rw_ctrl #(
        .DEV_ADDR (7'd5),
        .ADDR_ENDP(4'd4),
        .DATA_ENDP(4'd8),
        .MAX_TRIES(MT),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rst_L(rst_L),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    // Record every launch and response seen on the bus.
    always @(negedge clk) begin : monitor
        txn_t o;
        if (rst_L === 1'b1) begin
            if (bus.txn_start === 1'b1) begin
                o.cyc   = 32'(cyc);
                o.is_in = bus.txn_is_in;
                o.endp  = bus.txn_endp;
                o.wdata = bus.txn_wdata;
                obs_txn.push_back(o);
            end
            if (bus.rsp_valid === 1'b1) begin
                obs_rsp.n     = obs_rsp.n + 32'd1;
                obs_rsp.succ  = bus.rsp_success;
                obs_rsp.rdata = bus.rsp_rdata;
                obs_rsp.cyc   = 32'(cyc);
            end
        end
    end

    // Scripted transaction engine: each launch consumes one action.
    initial begin : engine
        act_t        a;
        bit          pend;
        int          cnt;
        int          spur_seen;
        logic        sv_in;
        logic [3:0]  sv_ep;
        logic [63:0] sv_wd;
        a = '0; pend = 0; cnt = 0; spur_seen = 0;
        sv_in = 1'b0; sv_ep = '0; sv_wd = '0;
        bus.txn_done  = 1'b0;
        bus.txn_ok    = 1'b0;
        bus.txn_rdata = '0;
        forever begin
            @(negedge clk);
            bus.txn_done = 1'b0;
            bus.txn_ok   = 1'b0;
            if (rst_L !== 1'b1) begin
                pend = 0;
            end else begin
                if (spur_req != spur_seen) begin
                    spur_seen     = spur_req;
                    bus.txn_done  = 1'b1;
                    bus.txn_ok    = 1'b1;
                    bus.txn_rdata = {$urandom(), $urandom()};
                end
                if (pend) begin
                    if (cnt == 0) begin
                        pend          = 0;
                        bus.txn_done  = 1'b1;
                        bus.txn_ok    = (a.kind == K_ACK);
                        bus.txn_rdata = (a.kind == K_ACK) ? a.rdata : {$urandom(), $urandom()};
                        vectors++;
                        if ({bus.txn_is_in, bus.txn_endp, bus.txn_wdata} !== {sv_in, sv_ep, sv_wd}) begin
                            miscompares++;
                            $display("FAIL txn_hold: fields at done in=%0b ep=%0d wd=%h, launched in=%0b ep=%0d wd=%h",
                                     bus.txn_is_in, bus.txn_endp, bus.txn_wdata, sv_in, sv_ep, sv_wd);
                        end
                    end else begin
                        cnt--;
                    end
                end
                if (bus.txn_start === 1'b1) begin
                    if (eng_q.size() > 0) a = eng_q.pop_front();
                    else a = {K_SIL, 8'd0, 64'd0};
                    sv_in = bus.txn_is_in;
                    sv_ep = bus.txn_endp;
                    sv_wd = bus.txn_wdata;
                    if (a.kind != K_SIL) begin
                        pend = 1;
                        cnt  = int'(a.dly);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_act(input logic [1:0] k, input logic [7:0] d, input logic [63:0] r);
        act_t a;
        a.kind = k; a.dly = d; a.rdata = r;
        script.push_back(a);
    endtask

    task automatic push_rand_act();
        int r;
        logic [1:0] k;
        logic [7:0] d;
        r = int'($urandom_range(0, 99));
        k = (r < 60) ? K_ACK : (r < 95) ? K_NAK : K_SIL;
        d = ($urandom_range(0, 19) == 0) ? 8'd254 : 8'($urandom_range(0, 4));
        push_act(k, d, {$urandom(), $urandom()});
    endtask

    task automatic prep();
        obs_txn.delete();
        exp_txn.delete();
        obs_rsp = '0;
        eng_q   = script;
    endtask

    task automatic start_req(input bit w, input logic [15:0] a, input logic [63:0] d, output int t);
        int n;
        n = 0;
        tick();
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            miscompares++;
            $display("FAIL req_ready_wait: req_ready still %b after %0d cycles, required 1", bus.req_ready, n);
        end
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        t = cyc;
        tick();
        bus.req_valid = 1'b0;
        rdy_after     = bus.req_ready;
    endtask

    task automatic wait_rsp(input int bound);
        int n;
        n = 0;
        while (obs_rsp.n == 0 && n < bound) begin
            tick();
            n++;
        end
        if (obs_rsp.n == 0) begin
            miscompares++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles, required one", bound);
        end
    endtask

    // Request-level model: each attempt consumes the next script action; an ACK
    // moves to the next phase, a NAK retries 2+dly cycles after launch, silence
    // retries TIMEOUT+1 cycles after launch; MAX_TRIES failures end the request.
    task automatic build_expect(input bit w, input logic [15:0] a, input logic [63:0] d, input int t0);
        int   t;
        int   idx;
        bit   ok;
        act_t ac;
        txn_t e;
        t = t0 + 1;
        idx = 0;
        ok = 0;
        exp_txn.delete();
        exp_rsp = '0;
        exp_rsp.n = 32'd1;
        for (int ph = 0; ph < 2; ph++) begin
            ok = 0;
            for (int n = 0; n < int'(MT) && !ok; n++) begin
                if (idx < script.size()) ac = script[idx];
                else ac = {K_SIL, 8'd0, 64'd0};
                idx++;
                e.cyc   = 32'(t);
                e.is_in = (ph == 1) && !w;
                e.endp  = (ph == 0) ? 4'd4 : 4'd8;
                e.wdata = (ph == 0) ? {48'h0, a} : (w ? d : 64'h0);
                exp_txn.push_back(e);
                if (ac.kind == K_SIL) begin
                    t = t + int'(TO) + 1;
                end else begin
                    t  = t + int'(ac.dly) + 2;
                    ok = (ac.kind == K_ACK);
                    if (ok && ph == 1 && !w) exp_rsp.rdata = ac.rdata;
                end
            end
            if (!ok) break;
        end
        exp_rsp.succ = ok;
        exp_rsp.cyc  = 32'(t);
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        idle(2);
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.rsp_rdata, bus.txn_start,
             bus.txn_is_in, bus.txn_endp, bus.txn_wdata, bus.txn_dev} !==
            {1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'h0, 64'h0, 7'd5}) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b rv=%b rs=%b rd=%h st=%b in=%b ep=%h wd=%h dev=%h, required 1 0 0 0 0 0 0 0 05",
                     bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.rsp_rdata, bus.txn_start,
                     bus.txn_is_in, bus.txn_endp, bus.txn_wdata, bus.txn_dev);
        end
        rst_L = 1'b1;
        idle(3);
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.txn_start} !== 3'b100) begin
            miscompares++;
            $display("FAIL idle_after_reset: rdy/rv/st=%b, required 100", {bus.req_ready, bus.rsp_valid, bus.txn_start});
        end
    endtask

    task automatic test_write_ok();
        int t;
        script.delete();
        push_act(K_ACK, 8'($urandom_range(0, 3)), {$urandom(), $urandom()});
        push_act(K_ACK, 8'($urandom_range(0, 3)), {$urandom(), $urandom()});
        prep();
        start_req(1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, t);
        build_expect(1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, t);
        wait_rsp(6000);
        idle(3);
        vectors++;
        if (rdy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_ready_drop: req_ready after accept %b, required 0", rdy_after);
        end
        vectors++;
        if (obs_txn.size() != exp_txn.size()) begin
            miscompares++;
            $display("FAIL wr_txn_count: %0d launches, required %0d", obs_txn.size(), exp_txn.size());
        end
        for (int i = 0; i < exp_txn.size() && i < obs_txn.size(); i++) begin
            vectors++;
            if (obs_txn[i] !== exp_txn[i]) begin
                miscompares++;
                $display("FAIL wr_txn%0d: got %h, required %h", i, obs_txn[i], exp_txn[i]);
            end
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL wr_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_read_ok();
        int t;
        script.delete();
        push_act(K_ACK, 8'd1, {$urandom(), $urandom()});
        push_act(K_ACK, 8'd2, 64'hDEAD_BEEF_0123_4567);
        prep();
        start_req(1'b0, 16'h1234, {$urandom(), $urandom()}, t);
        build_expect(1'b0, 16'h1234, 64'h0, t);
        wait_rsp(6000);
        idle(3);
        vectors++;
        if (obs_txn.size() != exp_txn.size()) begin
            miscompares++;
            $display("FAIL rd_txn_count: %0d launches, required %0d", obs_txn.size(), exp_txn.size());
        end
        for (int i = 0; i < exp_txn.size() && i < obs_txn.size(); i++) begin
            vectors++;
            if (obs_txn[i] !== exp_txn[i]) begin
                miscompares++;
                $display("FAIL rd_txn%0d: got %h, required %h", i, obs_txn[i], exp_txn[i]);
            end
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL rd_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_retry();
        int t;
        logic [15:0] a;
        logic [63:0] d;
        a = 16'($urandom());
        d = {$urandom(), $urandom()};
        script.delete();
        push_act(K_ACK, 8'd0, 64'h0);
        for (int i = 0; i < 7; i++) push_act(K_NAK, 8'($urandom_range(0, 3)), {$urandom(), $urandom()});
        push_act(K_ACK, 8'd0, {$urandom(), $urandom()});
        prep();
        start_req(1'b1, a, d, t);
        build_expect(1'b1, a, d, t);
        wait_rsp(6000);
        idle(3);
        vectors++;
        if (obs_txn.size() != 9) begin
            miscompares++;
            $display("FAIL retry_txn_count: %0d launches, required 9", obs_txn.size());
        end
        for (int i = 0; i < exp_txn.size() && i < obs_txn.size(); i++) begin
            vectors++;
            if (obs_txn[i] !== exp_txn[i]) begin
                miscompares++;
                $display("FAIL retry_txn%0d: got %h, required %h", i, obs_txn[i], exp_txn[i]);
            end
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL retry_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_exhaust();
        int t;
        script.delete();
        for (int i = 0; i < 8; i++) push_act(K_NAK, 8'($urandom_range(0, 5)), {$urandom(), $urandom()});
        push_act(K_ACK, 8'd0, 64'h0);
        push_act(K_ACK, 8'd0, 64'h1);
        prep();
        start_req(1'b0, 16'hBEEF, 64'h0, t);
        build_expect(1'b0, 16'hBEEF, 64'h0, t);
        wait_rsp(6000);
        idle(5);
        vectors++;
        if (obs_txn.size() != 8) begin
            miscompares++;
            $display("FAIL exh_txn_count: %0d launches, required 8", obs_txn.size());
        end
        for (int i = 0; i < exp_txn.size() && i < obs_txn.size(); i++) begin
            vectors++;
            if (obs_txn[i] !== exp_txn[i]) begin
                miscompares++;
                $display("FAIL exh_txn%0d: got %h, required %h", i, obs_txn[i], exp_txn[i]);
            end
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL exh_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_watchdog();
        int t;
        // eight silent attempts: launches 256 cycles apart, then a fail response
        script.delete();
        for (int i = 0; i < 8; i++) push_act(K_SIL, 8'd0, 64'h0);
        prep();
        start_req(1'b1, 16'h0042, 64'h1111_2222_3333_4444, t);
        build_expect(1'b1, 16'h0042, 64'h1111_2222_3333_4444, t);
        wait_rsp(6000);
        idle(3);
        vectors++;
        if (obs_txn.size() != exp_txn.size()) begin
            miscompares++;
            $display("FAIL wd_txn_count: %0d launches, required %0d", obs_txn.size(), exp_txn.size());
        end
        for (int i = 1; i < exp_txn.size() && i < obs_txn.size(); i++) begin
            vectors++;
            if (obs_txn[i].cyc - obs_txn[i-1].cyc !== 32'd256 || obs_txn[i] !== exp_txn[i]) begin
                miscompares++;
                $display("FAIL wd_txn%0d: got %h (gap %0d), required %h (gap 256)",
                         i, obs_txn[i], obs_txn[i].cyc - obs_txn[i-1].cyc, exp_txn[i]);
            end
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL wd_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
        // done landing on the expiry cycle counts as completion, both phases
        script.delete();
        push_act(K_SIL, 8'd0, 64'h0);
        push_act(K_ACK, 8'd254, 64'h0);
        push_act(K_ACK, 8'd254, 64'hCAFE_F00D_5555_AAAA);
        prep();
        start_req(1'b0, 16'h7777, 64'h0, t);
        build_expect(1'b0, 16'h7777, 64'h0, t);
        wait_rsp(6000);
        idle(3);
        vectors++;
        if (obs_txn.size() != 3) begin
            miscompares++;
            $display("FAIL wd_edge_count: %0d launches, required 3", obs_txn.size());
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL wd_edge_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_idle_done();
        prep();
        idle(2);
        spur_req++;
        idle(6);
        vectors++;
        if (obs_txn.size() != 0 || obs_rsp.n != 0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_done: launches %0d rsps %0d req_ready %b, required 0 0 1",
                     obs_txn.size(), obs_rsp.n, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   t1;
        int   t2;
        rsp_t r1;
        script.delete();
        push_act(K_ACK, 8'd0, 64'h0);
        push_act(K_ACK, 8'd0, 64'h0);
        prep();
        start_req(1'b1, 16'h0001, 64'h0123_4567_89AB_CDEF, t1);
        build_expect(1'b1, 16'h0001, 64'h0123_4567_89AB_CDEF, t1);
        wait_rsp(6000);
        r1 = obs_rsp;
        vectors++;
        if (r1 !== exp_rsp) begin
            miscompares++;
            $display("FAIL b2b_rsp1: got %h, required %h", r1, exp_rsp);
        end
        script.delete();
        push_act(K_ACK, 8'd3, 64'h0);
        push_act(K_ACK, 8'd0, 64'h0F0F_0F0F_F0F0_F0F0);
        prep();
        start_req(1'b0, 16'h0002, 64'h0, t2);
        build_expect(1'b0, 16'h0002, 64'h0, t2);
        vectors++;
        if (t2 != int'(r1.cyc) + 1) begin
            miscompares++;
            $display("FAIL b2b_accept: accepted at cycle %0d, required %0d", t2, int'(r1.cyc) + 1);
        end
        wait_rsp(6000);
        idle(2);
        vectors++;
        if (obs_txn.size() != 2 || obs_txn[0] !== exp_txn[0] || obs_txn[1] !== exp_txn[1]) begin
            miscompares++;
            $display("FAIL b2b_txns: %0d launches, first %h, required %h", obs_txn.size(),
                     (obs_txn.size() > 0) ? obs_txn[0] : '0, exp_txn[0]);
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL b2b_rsp2: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    task automatic test_random();
        int          t;
        bit          w;
        logic [15:0] a;
        logic [63:0] d;
        for (int r = 0; r < 20; r++) begin
            w = 1'($urandom());
            a = 16'($urandom());
            d = {$urandom(), $urandom()};
            script.delete();
            for (int i = 0; i < int'(2 * MT); i++) push_rand_act();
            prep();
            start_req(w, a, d, t);
            build_expect(w, a, d, t);
            wait_rsp(6000);
            idle(2);
            vectors++;
            if (obs_txn.size() != exp_txn.size()) begin
                miscompares++;
                $display("FAIL rnd%0d_txn_count: %0d launches, required %0d", r, obs_txn.size(), exp_txn.size());
            end
            for (int i = 0; i < exp_txn.size() && i < obs_txn.size(); i++) begin
                vectors++;
                if (obs_txn[i] !== exp_txn[i]) begin
                    miscompares++;
                    $display("FAIL rnd%0d_txn%0d: got %h, required %h", r, i, obs_txn[i], exp_txn[i]);
                end
            end
            vectors++;
            if (obs_rsp !== exp_rsp) begin
                miscompares++;
                $display("FAIL rnd%0d_rsp: got %h, required %h", r, obs_rsp, exp_rsp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        int n;
        script.delete();
        push_act(K_ACK, 8'd1, 64'h0);
        push_act(K_SIL, 8'd0, 64'h0);
        prep();
        start_req(1'b1, 16'h5A5A, 64'hA5A5_A5A5_A5A5_A5A5, t);
        n = 0;
        while (obs_txn.size() < 2 && n < 100) begin
            tick();
            n++;
        end
        idle(4);
        rst_L = 1'b0;
        #1;
        vectors++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_success, bus.rsp_rdata, bus.txn_start,
             bus.txn_is_in, bus.txn_endp, bus.txn_wdata, bus.txn_dev} !==
            {1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'h0, 64'h0, 7'd5}) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: rdy=%b rv=%b st=%b ep=%h wd=%h, required 1 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.txn_start, bus.txn_endp, bus.txn_wdata);
        end
        idle(2);
        rst_L = 1'b1;
        idle(300);
        vectors++;
        if (obs_rsp.n != 0 || obs_txn.size() != 2) begin
            miscompares++;
            $display("FAIL mid_reset_abandon: rsps %0d launches %0d, required 0 2", obs_rsp.n, obs_txn.size());
        end
        script.delete();
        push_act(K_ACK, 8'd2, 64'h0);
        push_act(K_ACK, 8'd1, 64'h0);
        prep();
        start_req(1'b1, 16'h0F0F, 64'h1357_9BDF_2468_ACE0, t);
        build_expect(1'b1, 16'h0F0F, 64'h1357_9BDF_2468_ACE0, t);
        wait_rsp(6000);
        idle(2);
        vectors++;
        if (obs_txn.size() != 2 || obs_txn[0] !== exp_txn[0] || obs_txn[1] !== exp_txn[1]) begin
            miscompares++;
            $display("FAIL mid_reset_next_txns: %0d launches, required 2 matching model", obs_txn.size());
        end
        vectors++;
        if (obs_rsp !== exp_rsp) begin
            miscompares++;
            $display("FAIL mid_reset_next_rsp: got %h, required %h", obs_rsp, exp_rsp);
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        spur_req      = 0;
        rdy_after     = 1'b0;
        obs_rsp       = '0;
        exp_rsp       = '0;
        rst_L         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_write_ok();
        test_read_ok();
        test_retry();
        test_exhaust();
        test_watchdog();
        test_idle_done();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
